// File: rtl/spy_capture_pkg.sv
// rtl/spy_capture_pkg.sv - shared state type and width helpers for the spy capture sequencer
package spy_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        POST    = 2'd2,
        READOUT = 2'd3
    } state_t;

    localparam int DATASIZE_DEF = 8;
    localparam int ADDRSIZE_DEF = 4;
    localparam int FILL_W       = ADDRSIZE_DEF + 1;

    function automatic int spy_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    // Fill counts up to DEPTH inclusive, so it needs one bit more than an address.
    function automatic int fill_width(input int addrsize);
        return addrsize + 1;
    endfunction

endpackage

// File: rtl/spy_capture_ctrl_if.sv
// rtl/spy_capture_ctrl_if.sv - spy memory port and readout stream bundle
interface spy_capture_ctrl_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
);
    logic [DATASIZE-1:0] mem_wdata;
    logic [ADDRSIZE-1:0] mem_waddr;
    logic                mem_wclken;
    logic                mem_wfull;
    logic [ADDRSIZE-1:0] mem_raddr;
    logic [DATASIZE-1:0] mem_rdata;

    logic [DATASIZE-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        output mem_wdata, mem_waddr, mem_wclken, mem_wfull, mem_raddr,
        output out_data, out_valid, out_last,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_wdata, mem_waddr, mem_wclken, mem_wfull, mem_raddr,
        input  out_data, out_valid, out_last,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/spy_capture_ctrl.sv
// rtl/spy_capture_ctrl.sv - circular spy-buffer capture, trigger freeze and oldest-first readout
module spy_capture_ctrl
    import spy_capture_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] in_data,
    input  logic                in_valid,
    input  logic                arm,
    input  logic                trigger,
    input  logic                abort,
    input  logic [ADDRSIZE-1:0] post_count,
    output logic                frozen,
    output logic                done,
    spy_capture_ctrl_if.master  bus
);

    localparam int DEPTH = spy_depth(ADDRSIZE);
    localparam int FW    = fill_width(ADDRSIZE);
    localparam logic [FW-1:0]       FILL_FULL = FW'(DEPTH);
    localparam logic [FW-1:0]       FILL_ONE  = FW'(1);
    localparam logic [ADDRSIZE-1:0] PTR_ONE   = ADDRSIZE'(1);

    state_t              state, state_n;
    logic [ADDRSIZE-1:0] wptr, wptr_n;
    logic [ADDRSIZE-1:0] rptr, rptr_n;
    logic [ADDRSIZE-1:0] post_cnt, post_cnt_n;
    logic [FW-1:0]       fill, fill_n;
    logic [FW-1:0]       remaining, remaining_n;
    logic                done_q, done_n;
    logic                wr_en;
    logic                enter_readout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            post_cnt  <= '0;
            fill      <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            post_cnt  <= post_cnt_n;
            fill      <= fill_n;
            remaining <= remaining_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        wptr_n        = wptr;
        rptr_n        = rptr;
        post_cnt_n    = post_cnt;
        fill_n        = fill;
        remaining_n   = remaining;
        done_n        = 1'b0;
        wr_en         = 1'b0;
        enter_readout = 1'b0;

        // Abort leaves fill untouched; the next arm clears it anyway.
        if (abort) begin
            state_n = IDLE;
        end else begin
            wr_en = in_valid && (state == ARMED || state == POST);
            if (wr_en) begin
                wptr_n = wptr + PTR_ONE;
                fill_n = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
            end

            case (state)
                IDLE: begin
                    if (arm) begin
                        state_n = ARMED;
                        wptr_n  = '0;
                        fill_n  = '0;
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        if (post_count == '0) begin
                            enter_readout = 1'b1;
                        end else begin
                            post_cnt_n = post_count;
                            state_n    = POST;
                        end
                    end
                end
                POST: begin
                    if (wr_en) begin
                        post_cnt_n = post_cnt - PTR_ONE;
                        if (post_cnt == PTR_ONE) begin
                            enter_readout = 1'b1;
                        end
                    end
                end
                READOUT: begin
                    if (bus.out_ready) begin
                        rptr_n      = rptr + PTR_ONE;
                        remaining_n = remaining - FILL_ONE;
                        if (remaining == FILL_ONE) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase

            // Once the buffer has wrapped, the oldest word sits where the next write would go.
            if (enter_readout) begin
                if (fill_n == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n     = READOUT;
                    rptr_n      = (fill_n == FILL_FULL) ? wptr_n : '0;
                    remaining_n = fill_n;
                end
            end
        end
    end

    assign bus.mem_wdata  = in_data;
    assign bus.mem_waddr  = wptr;
    assign bus.mem_wclken = wr_en;
    assign bus.mem_wfull  = 1'b0;
    assign bus.mem_raddr  = rptr;

    assign bus.out_valid  = (state == READOUT);
    assign bus.out_data   = (state == READOUT) ? bus.mem_rdata : '0;
    assign bus.out_last   = (state == READOUT) && (remaining == FILL_ONE);

    assign frozen = (state == READOUT);
    assign done   = done_q;

endmodule

// File: tb/tb_spy_capture_ctrl.sv
// tb/tb_spy_capture_ctrl.sv - randomized self-checking bench for spy_capture_ctrl
module tb_spy_capture_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] post_count = '0;
    logic          frozen;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [DEPTH];

    spy_capture_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

    spy_capture_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .arm        (arm),
        .trigger    (trigger),
        .abort      (abort),
        .post_count (post_count),
        .frozen     (frozen),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Spy memory: registered write, combinational read.
    always @(posedge clk) begin
        if (bus.mem_wclken) mem[bus.mem_waddr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_raddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [DW-1:0] d, input bit a, input bit t,
                         input bit ab, input logic [AW-1:0] pc, input bit rdy);
        @(negedge clk);
        in_valid      = iv;
        in_data       = d;
        arm           = a;
        trigger       = t;
        abort         = ab;
        post_count    = pc;
        bus.out_ready = rdy;
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic check_write(input bit v, input logic [DW-1:0] w, input int writes);
        chk("wclken", 32'(bus.mem_wclken), 32'(v));
        chk("wfull", 32'(bus.mem_wfull), 32'(0));
        if (v) begin
            chk("waddr", 32'(bus.mem_waddr), 32'(writes % DEPTH));
            chk("wdata", 32'(bus.mem_wdata), 32'(w));
        end
    endtask

    // Full capture: window model is simply "last DEPTH words written since arm".
    task automatic capture(input int n_pre, input int pc, input bit gaps, input int rdy_mode,
                           input bit seq, input logic [DW-1:0] base);
        logic [DW-1:0] win[$];
        logic [DW-1:0] w;
        logic [DW-1:0] dropped;
        int writes;
        int left;
        int idx;
        int cyc;
        bit v;
        bit rdy;
        writes = 0;

        drive(1'b1, 8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom), 1'b0);
        chk("idle_wclken", 32'(bus.mem_wclken), 32'(0));
        chk("idle_valid", 32'(bus.out_valid), 32'(0));

        left = n_pre;
        while (left > 0) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            w = seq ? base + 8'(writes) : 8'($urandom);
            drive(v, w, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'($urandom), 1'b0);
            check_write(v, w, writes);
            if (v) begin
                win.push_back(w);
                if (win.size() > DEPTH) dropped = win.pop_front();
                writes++;
                left--;
            end
        end

        w = seq ? base + 8'(writes) : 8'($urandom);
        drive(1'b1, w, 1'b0, 1'b1, 1'b0, 4'(pc), 1'b0);
        check_write(1'b1, w, writes);
        win.push_back(w);
        if (win.size() > DEPTH) dropped = win.pop_front();
        writes++;

        left = pc;
        while (left > 0) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            w = seq ? base + 8'(writes) : 8'($urandom);
            drive(v, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 4'($urandom), 1'b0);
            check_write(v, w, writes);
            if (v) begin
                win.push_back(w);
                if (win.size() > DEPTH) dropped = win.pop_front();
                writes++;
                left--;
            end
        end

        idx = 0;
        cyc = 0;
        while (idx < win.size() && cyc < 400) begin
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 4'($urandom), rdy);
            chk("ro_valid", 32'(bus.out_valid), 32'(1));
            chk("ro_frozen", 32'(frozen), 32'(1));
            chk("ro_data", 32'(bus.out_data), 32'(win[idx]));
            chk("ro_last", 32'(bus.out_last), 32'(idx == win.size() - 1));
            chk("ro_wclken", 32'(bus.mem_wclken), 32'(0));
            chk("ro_raddr", 32'(bus.mem_raddr), 32'((writes - win.size() + idx) % DEPTH));
            chk("ro_done", 32'(done), 32'(0));
            if (rdy) idx++;
            cyc++;
        end
        if (idx < win.size()) chk("ro_timeout", 32'(idx), 32'(win.size()));

        idle_cycle();
        chk("done_pulse", 32'(done), 32'(1));
        chk("post_valid", 32'(bus.out_valid), 32'(0));
        chk("post_frozen", 32'(frozen), 32'(0));
        idle_cycle();
        chk("done_clear", 32'(done), 32'(0));
    endtask

    initial begin
        bus.out_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_last", 32'(bus.out_last), 32'(0));
        chk("rst_frozen", 32'(frozen), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_wclken", 32'(bus.mem_wclken), 32'(0));
        chk("rst_waddr", 32'(bus.mem_waddr), 32'(0));
        chk("rst_raddr", 32'(bus.mem_raddr), 32'(0));
        chk("rst_data", 32'(bus.out_data), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 0x10..0x14, trigger on 0x14, no post words.
        capture(4, 0, 1'b0, 0, 1'b1, 8'h10);
        // Wrap: 0x00..0x1F, trigger on 0x1C with 3 post words.
        capture(28, 3, 1'b0, 0, 1'b1, 8'h00);
        // Stalled readout 1,0,0,1.
        capture(9, 2, 1'b0, 1, 1'b1, 8'h40);

        // Trigger while idle is ignored, as are incoming words.
        repeat (3) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
            chk("idle_trig_wclken", 32'(bus.mem_wclken), 32'(0));
            chk("idle_trig_valid", 32'(bus.out_valid), 32'(0));
            chk("idle_trig_done", 32'(done), 32'(0));
        end

        // Abort after 2 of 4 post words.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 8'h63, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 8'(8'h64 + i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b1);
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("abort_wclken", 32'(bus.mem_wclken), 32'(0));
        chk("abort_valid", 32'(bus.out_valid), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        idle_cycle();
        chk("abort_done2", 32'(done), 32'(0));
        capture(0, 0, 1'b0, 0, 1'b0, 8'h00);

        // Trigger with no word ever written: straight back to idle.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("empty_wclken", 32'(bus.mem_wclken), 32'(0));
        idle_cycle();
        chk("empty_done", 32'(done), 32'(1));
        chk("empty_valid", 32'(bus.out_valid), 32'(0));
        idle_cycle();
        chk("empty_done_clr", 32'(done), 32'(0));

        // Reset in the middle of readout.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 8'h84, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'(1));
        chk("pre_rst_data", 32'(bus.out_data), 32'(8'h80));
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_frozen", 32'(frozen), 32'(0));
        chk("mid_rst_last", 32'(bus.out_last), 32'(0));
        chk("mid_rst_data", 32'(bus.out_data), 32'(0));
        chk("mid_rst_waddr", 32'(bus.mem_waddr), 32'(0));
        chk("mid_rst_wclken", 32'(bus.mem_wclken), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("post_rst_wclken", 32'(bus.mem_wclken), 32'(0));
        chk("post_rst_valid", 32'(bus.out_valid), 32'(0));

        // Randomized captures.
        for (int k = 0; k < 8; k++) begin
            capture($urandom_range(0, 40), $urandom_range(0, 15), 1'b1,
                    $urandom_range(0, 2), 1'b0, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
